// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared state type, table limit and lookup helper for lut_settle_eval
package lut_pkg;

  localparam int TT_W_MAX = 64;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } lut_state_e;

  // tbl is left-aligned: table bit TT_W-1 sits at tbl[TT_W_MAX-1], so index 0 maps to the top bit
  function automatic logic tt_lookup(input logic [TT_W_MAX-1:0] tbl, input logic [5:0] idx);
    logic [5:0] pos;
    pos = 6'(TT_W_MAX - 1) - idx;
    return tbl[pos];
  endfunction

endpackage

// File: rtl/lut_settle_cnt.sv
// rtl/lut_settle_cnt.sv - input capture and settle counter; optional glitch counter under LUT_GLITCH_CNT_EN
module lut_settle_cnt #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_vec,
  input  logic            clr,
`ifdef LUT_GLITCH_CNT_EN
  input  logic            out_valid,
  output logic [7:0]      glitch_cnt,
`endif
  output logic [N_IN-1:0] in_q,
  output logic            changed,
  output logic            settled
);

  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

  logic [N_IN-1:0]  in_q_q, in_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_q    = in_q_q;
  assign changed = (in_vec != in_q_q);
  assign settled = !changed && (cnt_q == CNT_MAX);

  // cnt saturates at CNT_MAX, so inequality is the same test as "below SETTLE"
  always_comb begin
    in_q_d = in_q_q;
    cnt_d  = cnt_q;
    if (changed) begin
      in_q_d = in_vec;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q_q <= '0;
      cnt_q  <= '0;
    end else begin
      in_q_q <= in_q_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef LUT_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  assign glitch_cnt = glitch_q;

  always_comb begin
    glitch_d = glitch_q;
    if (changed && (cnt_q != CNT_MAX) && !out_valid && (glitch_q != 8'hFF))
      glitch_d = glitch_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) glitch_q <= '0;
    else        glitch_q <= glitch_d;
  end
`endif

endmodule

// File: rtl/lut_settle_eval.sv
// rtl/lut_settle_eval.sv - settled N-input truth-table evaluator with serial table reload
// Optional glitch_cnt output enabled by defining LUT_GLITCH_CNT_EN.
module lut_settle_eval
  import lut_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int TT_W = 2 ** N_IN,
  parameter logic [TT_W-1:0] TT_RESET = TT_W'(8'hE6),
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_vec,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            out,
  output logic            out_valid,
  output logic            out_chg
`ifdef LUT_GLITCH_CNT_EN
  ,
  output logic [7:0]      glitch_cnt
`endif
);

  localparam int BC_W = $clog2(TT_W + 1);

  lut_state_e      state_q, state_d;
  logic [TT_W-1:0] shadow_q, shadow_d;
  logic [TT_W-1:0] tt_active_q, tt_active_d;
  logic [BC_W-1:0] bitcnt_q, bitcnt_d;
  logic            out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            out_chg_q, out_chg_d;
  logic            cfg_done_q, cfg_done_d;

  logic [N_IN-1:0] in_q;
  logic            changed, settled, commit, new_out;

  lut_settle_cnt #(.N_IN(N_IN), .SETTLE(SETTLE)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vec     (in_vec),
    .clr        (commit),
`ifdef LUT_GLITCH_CNT_EN
    .out_valid  (out_valid_q),
    .glitch_cnt (glitch_cnt),
`endif
    .in_q       (in_q),
    .changed    (changed),
    .settled    (settled)
  );

  assign commit    = (state_q == COMMIT);
  assign cfg_ready = (state_q == LOAD);
  assign cfg_done  = cfg_done_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_chg   = out_chg_q;
  assign new_out   = tt_lookup(TT_W_MAX'(tt_active_q) << (TT_W_MAX - TT_W), 6'(in_q));

  // A cfg_start inside LOAD restarts the count and swallows a same-cycle bit
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bitcnt_d    = bitcnt_q;
    tt_active_d = tt_active_q;
    cfg_done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_start) begin
          state_d  = LOAD;
          bitcnt_d = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          bitcnt_d = '0;
        end else if (cfg_valid) begin
          shadow_d = {shadow_q[TT_W-2:0], cfg_bit};
          bitcnt_d = bitcnt_q + BC_W'(1);
          if (bitcnt_q == BC_W'(TT_W - 1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        tt_active_d = shadow_q;
        cfg_done_d  = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_chg_d   = 1'b0;
    if (changed) begin
      out_valid_d = 1'b0;
    end else if (settled && (state_q == RUN)) begin
      out_d       = new_out;
      out_valid_d = 1'b1;
      out_chg_d   = (new_out != out_q);
    end
    if (commit) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      shadow_q    <= '0;
      bitcnt_q    <= '0;
      tt_active_q <= TT_RESET;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_chg_q   <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bitcnt_q    <= bitcnt_d;
      tt_active_q <= tt_active_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_chg_q   <= out_chg_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

endmodule
